// File: rtl/scaler_read_sequencer.sv
// Coherent 28-bit scaler snapshot reader: lo/hi/lo strobe sequence with carry
// detection and bounded re-read, arbitrated round-robin across NREQ requesters.
module scaler_read_sequencer #(
  parameter int NREQ          = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int MAX_RETRY     = 3,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            CLOCK,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [13:0]     CHAT,
  input  logic [13:0]     CHBT,
  output logic            RCHAT_,
  output logic            RCHBT_,
  output logic [27:0]     rd_data,
  output logic [IDW-1:0]  rd_id,
  output logic            rd_valid,
  output logic            rd_err,
  output logic            busy
);

  localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LO1   = 3'd1;
  localparam logic [2:0] GAP1  = 3'd2;
  localparam logic [2:0] HI    = 3'd3;
  localparam logic [2:0] GAP2  = 3'd4;
  localparam logic [2:0] LO2   = 3'd5;
  localparam logic [2:0] CHECK = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  logic [2:0]     state, state_nxt;
  logic [SCW-1:0] scnt;
  logic [RCW-1:0] retry_cnt;
  logic [IDW-1:0] cur_id, rr_ptr, gnt_id;
  logic           gnt_any;
  logic [13:0]    lo1, lo2, hi;
  logic           strobe_st, last, wrap, can_retry;

  assign strobe_st = (state == LO1) || (state == HI) || (state == LO2);
  assign last      = (scnt == SCW'(STROBE_CYCLES - 1));
  assign wrap      = (lo2 < lo1);
  assign can_retry = (retry_cnt != RCW'(MAX_RETRY));

  // Cyclic priority search: descending loop so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = LO1;
      LO1:     if (last) state_nxt = GAP1;
      GAP1:    state_nxt = HI;
      HI:      if (last) state_nxt = GAP2;
      GAP2:    state_nxt = LO2;
      LO2:     if (last) state_nxt = CHECK;
      CHECK:   state_nxt = (wrap && can_retry) ? GAP1 : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      retry_cnt <= '0;
      cur_id    <= '0;
      rr_ptr    <= '0;
      lo1       <= '0;
      lo2       <= '0;
      hi        <= '0;
      RCHAT_    <= 1'b1;
      RCHBT_    <= 1'b1;
      rd_data   <= '0;
      rd_id     <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_nxt;
      scnt     <= (strobe_st && !last) ? scnt + 1'b1 : '0;
      // Strobes and busy follow the state being entered so they line up with it.
      RCHBT_   <= !((state_nxt == LO1) || (state_nxt == LO2));
      RCHAT_   <= !(state_nxt == HI);
      busy     <= (state_nxt != IDLE);
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (gnt_any) begin
          cur_id    <= gnt_id;
          retry_cnt <= '0;
        end
        LO1: if (last) lo1 <= CHBT;
        HI:  if (last) hi  <= CHAT;
        LO2: if (last) lo2 <= CHBT;
        CHECK: begin
          if (!wrap) begin
            rd_data <= {hi, lo1};
            rd_err  <= 1'b0;
          end else if (can_retry) begin
            // Low word carried between reads: restart from the newer low word.
            lo1       <= lo2;
            retry_cnt <= retry_cnt + 1'b1;
          end else begin
            rd_data <= {hi, lo2};
            rd_err  <= 1'b1;
          end
        end
        DONE: begin
          rd_valid <= 1'b1;
          rd_id    <= cur_id;
          rr_ptr   <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scaler_read_sequencer.sv
// Bench for scaler_read_sequencer: directed vector table, reset-abort sequence,
// and randomized reads checked against a read-sequence reference model.
module tb_scaler_read_sequencer;
  localparam int NREQ = 2;
  localparam int S    = 2;
  localparam int MR   = 3;

  logic            CLOCK = 1'b0;
  logic            rst   = 1'b0;
  logic [NREQ-1:0] req   = '0;
  logic [13:0]     CHAT  = '0;
  logic [13:0]     CHBT  = '0;
  logic            RCHAT_, RCHBT_, rd_valid, rd_err, busy;
  logic [27:0]     rd_data;
  logic [0:0]      rd_id;

  int checks = 0;
  int errors = 0;
  logic [13:0] lo_q[$];
  logic [13:0] hi_q[$];

  scaler_read_sequencer #(.NREQ(NREQ), .STROBE_CYCLES(S), .MAX_RETRY(MR)) dut (
    .CLOCK(CLOCK), .rst(rst), .req(req), .CHAT(CHAT), .CHBT(CHBT),
    .RCHAT_(RCHAT_), .RCHBT_(RCHBT_), .rd_data(rd_data), .rd_id(rd_id),
    .rd_valid(rd_valid), .rd_err(rd_err), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  // Scaler stand-in: each new strobe presents the next scripted word.
  always @(negedge RCHBT_) CHBT = (lo_q.size() > 0) ? lo_q.pop_front() : 14'($urandom);
  always @(negedge RCHAT_) CHAT = (hi_q.size() > 0) ? hi_q.pop_front() : 14'($urandom);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Strobe exclusivity and gap monitor.
  logic pa = 1'b1, pb = 1'b1;
  always @(negedge CLOCK) begin
    if (rst) begin
      pa <= 1'b1; pb <= 1'b1;
    end else begin
      if (!RCHAT_ || !RCHBT_) begin
        checks++;
        if ((!RCHAT_ && !RCHBT_) || (!RCHAT_ && !pb) || (!RCHBT_ && !pa)) begin
          errors++;
          $display("FAIL strobe_sep: RCHAT_=%b RCHBT_=%b prevA=%b prevB=%b required separated", RCHAT_, RCHBT_, pa, pb);
        end
      end
      pa <= RCHAT_; pb <= RCHBT_;
    end
  end

  // Reference: walk the words the scaler handed out in read order.
  function automatic void ref_read(input logic [4:0][13:0] lov, input logic [3:0][13:0] hiv,
                                   output logic [27:0] d, output bit e, output int lat);
    logic [13:0] l1;
    l1 = lov[0]; d = '0; e = 0; lat = 3*S + 4;
    for (int k = 0; k <= MR; k++) begin
      if (lov[k+1] >= l1) begin d = {hiv[k], l1}; return; end
      if (k == MR) begin d = {hiv[k], lov[k+1]}; e = 1; return; end
      l1  = lov[k+1];
      lat += 2*S + 3;
    end
  endfunction

  task automatic load(input logic [4:0][13:0] lov, input logic [3:0][13:0] hiv);
    lo_q.delete(); hi_q.delete();
    for (int i = 0; i < 5; i++) lo_q.push_back(lov[i]);
    for (int i = 0; i < 4; i++) hi_q.push_back(hiv[i]);
  endtask

  // Call just after a posedge with the DUT idle; the next edge samples req.
  task automatic run_txn(input logic [NREQ-1:0] mask, input int drop_at, output int lat);
    bit seen;
    seen = 0; lat = -1; req = mask;
    for (int n = 1; n <= 300 && !seen; n++) begin
      @(posedge CLOCK); #1;
      if (n == 1) chk("busy_after_grant", 32'(busy), 32'd1);
      if (n == drop_at) req = '0;
      if (rd_valid) begin seen = 1; lat = n - 1; end
    end
    req = '0;
    if (!seen) chk("rd_valid_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [NREQ-1:0]   req;
    logic [4:0][13:0]  lo;
    logic [3:0][13:0]  hi;
    logic [27:0]       exp_data;
    int                exp_id;
    bit                exp_err;
    int                exp_lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat, rr, exp_id, exp_lat, drop;
    logic [27:0] exp_d;
    bit exp_e;
    logic [4:0][13:0] lv;
    logic [3:0][13:0] hv;
    logic [NREQ-1:0] m;

    // {req, lo words in read order, hi words in read order, expected}
    tbl[0] = '{2'b01, {14'h0, 14'h0, 14'h0, 14'h0102, 14'h0100}, {14'h0, 14'h0, 14'h0, 14'h0005}, 28'h0014100, 0, 0, 10};
    tbl[1] = '{2'b01, {14'h0, 14'h0, 14'h0002, 14'h0001, 14'h3FFF}, {14'h0, 14'h0, 14'h0006, 14'h0005}, 28'h0018001, 0, 0, 17};
    tbl[2] = '{2'b10, {14'h0, 14'h0, 14'h0, 14'h2000, 14'h2000}, {14'h0, 14'h0, 14'h0, 14'h3FFF}, 28'hFFFE000, 1, 0, 10};
    tbl[3] = '{2'b11, {14'h00FC, 14'h00FD, 14'h00FE, 14'h00FF, 14'h0100}, {14'h0004, 14'h0003, 14'h0002, 14'h0001}, 28'h00100FC, 0, 1, 31};
    tbl[4] = '{2'b11, {14'h0, 14'h0, 14'h0, 14'h0000, 14'h0000}, {14'h0, 14'h0, 14'h0, 14'h0000}, 28'h0000000, 1, 0, 10};
    tbl[5] = '{2'b11, {14'h0, 14'h0, 14'h0, 14'h3FFF, 14'h3FFE}, {14'h0, 14'h0, 14'h0, 14'h2AAA}, 28'hAAABFFE, 0, 0, 10};

    #2 rst = 1'b1;
    #2;
    chk("rst_RCHAT_", 32'(RCHAT_), 32'd1);
    chk("rst_RCHBT_", 32'(RCHBT_), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_id", 32'(rd_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge CLOCK); rst = 1'b0;
    @(posedge CLOCK); #1;

    for (int i = 0; i < 6; i++) begin
      load(tbl[i].lo, tbl[i].hi);
      run_txn(tbl[i].req, 0, lat);
      chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
      chk($sformatf("vec%0d_id", i), 32'(rd_id), 32'(tbl[i].exp_id));
      chk($sformatf("vec%0d_err", i), 32'(rd_err), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
    end

    // Reset in the middle of HI: strobes release at once, read is abandoned.
    load({14'h0, 14'h0, 14'h0, 14'h0020, 14'h0010}, {14'h0, 14'h0, 14'h0, 14'h0111});
    req = 2'b11;
    begin
      bit hit;
      hit = 0;
      for (int n = 0; n < 50 && !hit; n++) begin
        @(posedge CLOCK); #1;
        if (!RCHAT_) hit = 1;
      end
      chk("reach_HI", 32'(hit), 32'd1);
    end
    rst = 1'b1; #1;
    chk("midrst_RCHAT_", 32'(RCHAT_), 32'd1);
    chk("midrst_RCHBT_", 32'(RCHBT_), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    req = '0;
    for (int n = 0; n < 3; n++) begin
      @(posedge CLOCK); #1;
      chk("midrst_no_valid", 32'(rd_valid), 32'd0);
    end
    @(negedge CLOCK); rst = 1'b0;
    @(posedge CLOCK); #1;
    chk("post_rst_no_valid", 32'(rd_valid), 32'd0);
    load({14'h0, 14'h0, 14'h0, 14'h0020, 14'h0010}, {14'h0, 14'h0, 14'h0, 14'h0111});
    run_txn(2'b11, 0, lat);
    chk("post_rst_id", 32'(rd_id), 32'd0);
    chk("post_rst_data", 32'(rd_data), 32'h0444010);
    chk("post_rst_latency", 32'(lat), 32'd10);

    // Randomized reads, including requests dropped mid-read.
    rr = 1;
    for (int t = 0; t < 40; t++) begin
      m = NREQ'($urandom_range(1, 3));
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 8) : 0;
      lv[0] = 14'($urandom);
      for (int k = 0; k < 4; k++) begin
        hv[k] = 14'($urandom);
        lv[k+1] = ($urandom_range(0, 1) == 1) ? lv[k] + 14'($urandom_range(0, 3)) : 14'($urandom);
      end
      exp_id = m[rr] ? rr : (rr + 1) % NREQ;
      ref_read(lv, hv, exp_d, exp_e, exp_lat);
      load(lv, hv);
      run_txn(m, drop, lat);
      chk($sformatf("rnd%0d_data", t), 32'(rd_data), 32'(exp_d));
      chk($sformatf("rnd%0d_err", t), 32'(rd_err), 32'(exp_e));
      chk($sformatf("rnd%0d_id", t), 32'(rd_id), 32'(exp_id));
      chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(exp_lat));
      rr = (exp_id + 1) % NREQ;
      @(posedge CLOCK); #1;
      chk($sformatf("rnd%0d_valid_pulse", t), 32'(rd_valid), 32'd0);
      chk($sformatf("rnd%0d_idle", t), 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
